// File: rtl/overlay_sched_pkg.sv
// Shared types and constants for the two-channel overlay scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package overlay_sched_pkg;

  // Default width of each I and Q word.
  localparam int DEF_DATA_W = 16;

  // Channel tags carried alongside each sample.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // One complex sample: I in the upper half, Q in the lower half.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] i;
    logic [DEF_DATA_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/overlay_iq_fifo.sv
// Synchronous FIFO of IQ samples with occupancy count, full and empty flags.
// Latency: a write is visible at rd_dat from the cycle after it is accepted (no bypass).
// Backpressure: writes while full and reads while empty are ignored; full is taken from the registered count.
module overlay_iq_fifo
  import overlay_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  iq_sample_t       wr_dat,
  input  logic             rd_vld,
  output iq_sample_t       rd_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  iq_sample_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_vld & ~full;
  assign rd_fire = rd_vld & ~empty;
  assign rd_dat  = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end
  end

endmodule

// File: rtl/overlay_chan_scheduler.sv
// Shares one processing engine between two IQ channels: per-channel FIFOs, round-robin grant, tagged return demux.
// Latency: input strobe to o_eng_valid is 2 cycles when idle; engine result to output strobe is 1 cycle.
// Backpressure: o_eng_* hold until i_eng_ready; a full FIFO drops the sample and sets a sticky overflow bit.
module overlay_chan_scheduler
  import overlay_sched_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr_status,
  input  logic [DATA_W-1:0] i_I0_data,
  input  logic [DATA_W-1:0] i_Q0_data,
  input  logic              i_I0_valid,
  input  logic              i_Q0_valid,
  input  logic [DATA_W-1:0] i_I1_data,
  input  logic [DATA_W-1:0] i_Q1_data,
  input  logic              i_I1_valid,
  input  logic              i_Q1_valid,
  output logic [DATA_W-1:0] o_eng_I,
  output logic [DATA_W-1:0] o_eng_Q,
  output logic              o_eng_ch,
  output logic              o_eng_valid,
  input  logic              i_eng_ready,
  input  logic [DATA_W-1:0] i_eng_I,
  input  logic [DATA_W-1:0] i_eng_Q,
  input  logic              i_eng_ch,
  input  logic              i_eng_valid,
  output logic [DATA_W-1:0] o_I0_data,
  output logic [DATA_W-1:0] o_Q0_data,
  output logic [DATA_W-1:0] o_I1_data,
  output logic [DATA_W-1:0] o_Q1_data,
  output logic              o_I0_valid,
  output logic              o_Q0_valid,
  output logic              o_I1_valid,
  output logic              o_Q1_valid,
  output logic [1:0]        o_ovf,
  output logic [1:0]        o_mismatch
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  iq_sample_t       wr_dat0, wr_dat1;
  iq_sample_t       rd_dat0, rd_dat1;
  logic             both0, both1;
  logic             wr_vld0, wr_vld1;
  logic             rd_vld0, rd_vld1;
  logic             full0, full1;
  logic             empty0, empty1;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic [1:0]       ovf_set;
  logic [1:0]       mismatch_set;
  logic             last_grant;
  logic             load;
  logic             gnt;
  iq_sample_t       sel_dat;
  logic             unused_cnt;

  // Occupancy counts are kept as named nets for observability only.
  assign unused_cnt = ^{cnt0, cnt1};

  assign both0   = i_I0_valid & i_Q0_valid;
  assign both1   = i_I1_valid & i_Q1_valid;
  assign wr_vld0 = both0 & ~full0;
  assign wr_vld1 = both1 & ~full1;
  assign wr_dat0 = '{i: i_I0_data, q: i_Q0_data};
  assign wr_dat1 = '{i: i_I1_data, q: i_Q1_data};

  assign ovf_set      = {both1 & full1, both0 & full0};
  assign mismatch_set = {i_I1_valid ^ i_Q1_valid, i_I0_valid ^ i_Q0_valid};

  overlay_iq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .wr_vld (wr_vld0),
    .wr_dat (wr_dat0),
    .rd_vld (rd_vld0),
    .rd_dat (rd_dat0),
    .count  (cnt0),
    .full   (full0),
    .empty  (empty0)
  );

  overlay_iq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .wr_vld (wr_vld1),
    .wr_dat (wr_dat1),
    .rd_vld (rd_vld1),
    .rd_dat (rd_dat1),
    .count  (cnt1),
    .full   (full1),
    .empty  (empty1)
  );

  // Round-robin grant: alternate on contention, otherwise take whichever channel has data.
  always_comb begin
    load    = 1'b0;
    gnt     = CH0;
    rd_vld0 = 1'b0;
    rd_vld1 = 1'b0;
    sel_dat = rd_dat0;
    load = (~o_eng_valid | i_eng_ready) & i_en & (~empty0 | ~empty1);
    if (~empty0 & ~empty1) begin
      gnt = ~last_grant;
    end else begin
      gnt = empty0 ? CH1 : CH0;
    end
    if (gnt == CH1) begin
      sel_dat = rd_dat1;
    end
    rd_vld0 = load & (gnt == CH0);
    rd_vld1 = load & (gnt == CH1);
  end

  // Engine request register: refills on handshake or when empty, otherwise holds stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_eng_valid <= 1'b0;
      o_eng_I     <= '0;
      o_eng_Q     <= '0;
      o_eng_ch    <= CH0;
      last_grant  <= CH1;
    end else if (load) begin
      o_eng_valid <= 1'b1;
      o_eng_I     <= sel_dat.i;
      o_eng_Q     <= sel_dat.q;
      o_eng_ch    <= gnt;
      last_grant  <= gnt;
    end else if (i_eng_ready) begin
      o_eng_valid <= 1'b0;
    end
  end

  // Return demux: capture tagged result into its channel and pulse that channel's strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_I0_data  <= '0;
      o_Q0_data  <= '0;
      o_I1_data  <= '0;
      o_Q1_data  <= '0;
      o_I0_valid <= 1'b0;
      o_Q0_valid <= 1'b0;
      o_I1_valid <= 1'b0;
      o_Q1_valid <= 1'b0;
    end else begin
      o_I0_valid <= i_eng_valid & (i_eng_ch == CH0);
      o_Q0_valid <= i_eng_valid & (i_eng_ch == CH0);
      o_I1_valid <= i_eng_valid & (i_eng_ch == CH1);
      o_Q1_valid <= i_eng_valid & (i_eng_ch == CH1);
      if (i_eng_valid && i_eng_ch == CH0) begin
        o_I0_data <= i_eng_I;
        o_Q0_data <= i_eng_Q;
      end
      if (i_eng_valid && i_eng_ch == CH1) begin
        o_I1_data <= i_eng_I;
        o_Q1_data <= i_eng_Q;
      end
    end
  end

  // Sticky status: a set event in the clear cycle keeps the bit high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf      <= '0;
      o_mismatch <= '0;
    end else begin
      o_ovf      <= (i_clr_status ? 2'b00 : o_ovf) | ovf_set;
      o_mismatch <= (i_clr_status ? 2'b00 : o_mismatch) | mismatch_set;
    end
  end

endmodule
